mcu_bus_sync: RTL

Parametrised, clock-synchronous interface to a multiplexed 8051-style external bus (ALE, WR_N, RD_N, AD). It synchronises the asynchronous bus strobes into the system clock domain and latches the address on ALE's falling edge. It decodes block chip-selects and register one-hots, and issues single-cycle write/read strobes to the motor-control register blocks. It replaces the free-running ALE-clocked address latch with a single-clock design that has an explicit bus-cycle state machine and an optional read-back path.

---
 rtl/mcu_bus_pkg.sv | 17 +
 rtl/mcu_bus_sync_if.sv | 41 ++++
 rtl/mcu_bus_edge_sync.sv | 34 +++
 rtl/mcu_bus_sync.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/mcu_bus_pkg.sv
// mcu_bus_pkg: shared types and default sizing for the 8051-style bus
// interface. The READ state exists only when MCU_BUS_READ_EN is defined.
package mcu_bus_pkg;

   localparam int unsigned AW_DEF   = 8;
   localparam int unsigned DW_DEF   = 8;
   localparam int unsigned CSW_DEF  = 4;
   localparam int unsigned PW_DEF   = 4;
   localparam int unsigned SYNC_DEF = 2;

`ifdef MCU_BUS_READ_EN
   typedef enum logic [1:0] {IDLE, ADDR, WRITE, READ} bus_state_t;
`else
   typedef enum logic [1:0] {IDLE, ADDR, WRITE} bus_state_t;
`endif

endpackage

// File: rtl/mcu_bus_sync_if.sv
// mcu_bus_sync_if: multiplexed MCU bus plus register-block side signals.
//   slave  : used by mcu_bus_sync (bus pins in, decoded/strobe outputs out)
//   master : the MCU / register-block side (drives pins and RdData)
//   ALE, WR_N, RD_N, AD  - asynchronous MCU bus pins
//   Addr, AddrValid, CS, MCUportL - latched address and decodes
//   WrStb, WrData, RdStb, RdData  - register block access
//   Dout, DoutOE - read-back pad drive
interface mcu_bus_sync_if #(
   parameter int unsigned AW  = 8,
   parameter int unsigned DW  = 8,
   parameter int unsigned CSW = 4,
   parameter int unsigned PW  = 4
);
   localparam int unsigned NCS = 2**CSW;
   localparam int unsigned NP  = 2**PW;

   logic           ALE;
   logic           WR_N;
   logic           RD_N;
   logic [DW-1:0]  AD;
   logic [AW-1:0]  Addr;
   logic           AddrValid;
   logic [NCS-1:0] CS;
   logic [NP-1:0]  MCUportL;
   logic           WrStb;
   logic [DW-1:0]  WrData;
   logic           RdStb;
   logic [DW-1:0]  RdData;
   logic [DW-1:0]  Dout;
   logic           DoutOE;

   modport slave (
      input  ALE, WR_N, RD_N, AD, RdData,
      output Addr, AddrValid, CS, MCUportL, WrStb, WrData, RdStb, Dout, DoutOE
   );

   modport master (
      output ALE, WR_N, RD_N, AD, RdData,
      input  Addr, AddrValid, CS, MCUportL, WrStb, WrData, RdStb, Dout, DoutOE
   );
endinterface

// File: rtl/mcu_bus_edge_sync.sv
// mcu_bus_edge_sync: SYNC-stage synchroniser for one asynchronous strobe,
// with single-cycle rise/fall pulses from the last stage vs. its delayed copy.
//   clk, rst_n : clock, async active-low reset
//   d          : asynchronous input
//   q          : synchronised level
//   rise, fall : one-cycle edge pulses
module mcu_bus_edge_sync #(
   parameter int unsigned SYNC    = 2,
   parameter logic        RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);
   logic [SYNC-1:0] stg;
   logic            q_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stg <= {SYNC{RST_VAL}};
         q_d <= RST_VAL;
      end else begin
         stg <= {stg[SYNC-2:0], d};
         q_d <= stg[SYNC-1];
      end
   end

   assign q    = stg[SYNC-1];
   assign rise = q & ~q_d;
   assign fall = ~q & q_d;
endmodule

// File: rtl/mcu_bus_sync.sv
// mcu_bus_sync: single-clock interface to a multiplexed 8051-style bus.
// Synchronises ALE/WR_N/RD_N/AD, latches the address on ALE fall, decodes
// active-low chip-selects and one-hot port lines, and issues one-cycle
// write (and optionally read) strobes.
//   CLK, RST_N : system clock, async active-low reset
//   bus        : mcu_bus_sync_if.slave (pins in, decodes/strobes out)
// Build option: MCU_BUS_READ_EN enables READ state, RdStb, Dout, DoutOE;
// without it RD_N and RdData are ignored and the read outputs are 0.
module mcu_bus_sync
   import mcu_bus_pkg::*;
#(
   parameter int unsigned AW   = AW_DEF,
   parameter int unsigned DW   = DW_DEF,
   parameter int unsigned CSW  = CSW_DEF,
   parameter int unsigned PW   = PW_DEF,
   parameter int unsigned SYNC = SYNC_DEF
) (
   input  logic          CLK,
   input  logic          RST_N,
   mcu_bus_sync_if.slave bus
);
   localparam int unsigned NCS = 2**CSW;
   localparam int unsigned NP  = 2**PW;

   bus_state_t state, state_nx;

   logic                    ale_rise, ale_fall, unused_ale_q;
   logic                    wr_q, wr_rise, wr_fall;
   logic [SYNC-1:0][DW-1:0] ad_stg;
   logic [DW-1:0]           ad_s;

   logic                    addr_ld, wrdata_ld, wrstb_nx;
   logic [AW-1:0]           addr;
   logic                    addrvalid;
   logic                    wrstb;
   logic [DW-1:0]           wrdata;
   logic [NCS-1:0]          cs;
   logic [NP-1:0]           portl;

   mcu_bus_edge_sync #(.SYNC(SYNC), .RST_VAL(1'b0)) u_ale (
      .clk(CLK), .rst_n(RST_N), .d(bus.ALE),
      .q(unused_ale_q), .rise(ale_rise), .fall(ale_fall)
   );

   mcu_bus_edge_sync #(.SYNC(SYNC), .RST_VAL(1'b1)) u_wr (
      .clk(CLK), .rst_n(RST_N), .d(bus.WR_N),
      .q(wr_q), .rise(wr_rise), .fall(wr_fall)
   );

`ifdef MCU_BUS_READ_EN
   logic          rd_rise, rd_fall, unused_rd_q;
   logic          rdstb_nx, rdstb, doutoe;
   logic [DW-1:0] dout;

   mcu_bus_edge_sync #(.SYNC(SYNC), .RST_VAL(1'b1)) u_rd (
      .clk(CLK), .rst_n(RST_N), .d(bus.RD_N),
      .q(unused_rd_q), .rise(rd_rise), .fall(rd_fall)
   );
`else
   logic unused_rd;
   assign unused_rd = ^{bus.RD_N, bus.RdData};
`endif

   // AD is sampled with the same depth as the strobes so the latched value
   // lines up with the synchronised ALE/WR_N edge that uses it.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) ad_stg <= '0;
      else        ad_stg <= {ad_stg[SYNC-2:0], bus.AD};
   end
   assign ad_s = ad_stg[SYNC-1];

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= IDLE;
      else        state <= state_nx;
   end

   // ALE fall wins in any state; ALE rise aborts an active bus cycle.
   // Strobe fall edges only start a cycle from ADDR, WR_N over RD_N.
   always_comb begin
      state_nx = state;
      if (ale_fall) begin
         state_nx = ADDR;
      end else begin
         case (state)
            IDLE:  state_nx = IDLE;
            ADDR: begin
               if (wr_fall) state_nx = WRITE;
`ifdef MCU_BUS_READ_EN
               else if (rd_fall) state_nx = READ;
`endif
            end
            WRITE: if (ale_rise || wr_rise) state_nx = ADDR;
`ifdef MCU_BUS_READ_EN
            READ:  if (ale_rise || rd_rise) state_nx = ADDR;
`endif
            default: state_nx = IDLE;
         endcase
      end
   end

   always_comb begin
      addr_ld   = ale_fall;
      wrdata_ld = (state == WRITE) && !wr_q;
      wrstb_nx  = (state == WRITE) && wr_rise && !ale_rise && !ale_fall;
`ifdef MCU_BUS_READ_EN
      rdstb_nx  = (state == ADDR) && rd_fall && !wr_fall && !ale_fall;
`endif
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         addr      <= '0;
         addrvalid <= 1'b0;
         wrstb     <= 1'b0;
         wrdata    <= '0;
      end else begin
         if (addr_ld) begin
            addr      <= ad_s[AW-1:0];
            addrvalid <= 1'b1;
         end
         if (wrdata_ld) wrdata <= ad_s;
         wrstb <= wrstb_nx;
      end
   end

`ifdef MCU_BUS_READ_EN
   // Output enable starts the edge after RdStb and holds while READ persists.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rdstb  <= 1'b0;
         dout   <= '0;
         doutoe <= 1'b0;
      end else begin
         rdstb  <= rdstb_nx;
         if (rdstb) dout <= bus.RdData;
         doutoe <= (state_nx == READ) && (rdstb || doutoe);
      end
   end
   assign bus.RdStb  = rdstb;
   assign bus.Dout   = dout;
   assign bus.DoutOE = doutoe;
`else
   assign bus.RdStb  = 1'b0;
   assign bus.Dout   = '0;
   assign bus.DoutOE = 1'b0;
`endif

   always_comb begin
      cs    = '1;
      portl = '0;
      if (addrvalid) begin
         cs[addr[AW-1 -: CSW]] = 1'b0;
         portl[addr[PW-1:0]]   = 1'b1;
      end
   end

   assign bus.Addr      = addr;
   assign bus.AddrValid = addrvalid;
   assign bus.CS        = cs;
   assign bus.MCUportL  = portl;
   assign bus.WrStb     = wrstb;
   assign bus.WrData    = wrdata;
endmodule
